// File: rtl/vga_vram_write_arbiter_if.sv
// Request/response bundle between the MiniAlu decode side and the VRAM write arbiter.
// The master drives the CPU pixel and fill requests; the slave returns fill status and the VRAM write port.
interface vga_vram_write_arbiter_if #(
  parameter int COORD_WIDTH = 8,
  parameter int COLOR_WIDTH = 3
);
  logic                       iCpuWrite;
  logic [COORD_WIDTH-1:0]     iCpuX;
  logic [COORD_WIDTH-1:0]     iCpuY;
  logic [COLOR_WIDTH-1:0]     iCpuColor;
  logic                       iFillStart;
  logic [COORD_WIDTH-1:0]     iFillX0;
  logic [COORD_WIDTH-1:0]     iFillY0;
  logic [COORD_WIDTH-1:0]     iFillW;
  logic [COORD_WIDTH-1:0]     iFillH;
  logic [COLOR_WIDTH-1:0]     iFillColor;
  logic                       oFillBusy;
  logic                       oFillDone;
  logic [2*COORD_WIDTH-1:0]   oPixelCount;
  logic                       oWriteEnable;
  logic [2*COORD_WIDTH-1:0]   oWriteAddress;
  logic [COLOR_WIDTH-1:0]     oDataOut;

  modport master (
    output iCpuWrite, iCpuX, iCpuY, iCpuColor,
    output iFillStart, iFillX0, iFillY0, iFillW, iFillH, iFillColor,
    input  oFillBusy, oFillDone, oPixelCount,
    input  oWriteEnable, oWriteAddress, oDataOut
  );

  modport slave (
    input  iCpuWrite, iCpuX, iCpuY, iCpuColor,
    input  iFillStart, iFillX0, iFillY0, iFillW, iFillH, iFillColor,
    output oFillBusy, oFillDone, oPixelCount,
    output oWriteEnable, oWriteAddress, oDataOut
  );
endinterface

// File: rtl/vga_vram_write_arbiter.sv
// Shares the single VRAM write port between CPU pixel writes and a rectangle-fill engine.
// The CPU always wins; a CPU write stalls the fill cursor for that cycle.
module vga_vram_write_arbiter #(
  parameter int COORD_WIDTH = 8,
  parameter int COLOR_WIDTH = 3
) (
  input logic                  Clock,
  input logic                  Reset,
  vga_vram_write_arbiter_if.slave bus
);
  localparam int ADDR_WIDTH = 2 * COORD_WIDTH;
  localparam logic [COORD_WIDTH-1:0] COORD_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0]  COUNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state, nextState;

  logic                   cpuVld_p0;
  logic [ADDR_WIDTH-1:0]  cpuAddr_p0;
  logic [COLOR_WIDTH-1:0] cpuColor_p0;

  logic [COORD_WIDTH-1:0] x0, fillW, fillH;
  logic [COLOR_WIDTH-1:0] fillColor;
  logic [COORD_WIDTH-1:0] cx, cy, col, row;
  logic [ADDR_WIDTH-1:0]  pixelCount;

  logic                   writeEnable_p1;
  logic [ADDR_WIDTH-1:0]  writeAddress_p1;
  logic [COLOR_WIDTH-1:0] dataOut_p1;
  logic                   fillBusy_p1;
  logic                   fillDone_p1;

  logic startAccept, sizeNonZero, fillStep, rowEnd, lastPixel;

  always_comb begin
    startAccept = (state == IDLE) && bus.iFillStart;
    sizeNonZero = (bus.iFillW != '0) && (bus.iFillH != '0);
    fillStep    = (state == FILL) && !cpuVld_p0;
    rowEnd      = (col == fillW - COORD_ONE);
    lastPixel   = rowEnd && (row == fillH - COORD_ONE);
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startAccept) nextState = sizeNonZero ? FILL : DONE;
      FILL:    if (fillStep && lastPixel) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  // Stage p0: capture CPU request and fill parameters; these carry no reset
  always_ff @(posedge Clock) begin
    cpuAddr_p0  <= {bus.iCpuY, bus.iCpuX};
    cpuColor_p0 <= bus.iCpuColor;
    if (startAccept) begin
      x0        <= bus.iFillX0;
      fillW     <= bus.iFillW;
      fillH     <= bus.iFillH;
      fillColor <= bus.iFillColor;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cpuVld_p0       <= 1'b0;
      cx              <= '0;
      cy              <= '0;
      col             <= '0;
      row             <= '0;
      pixelCount      <= '0;
      writeEnable_p1  <= 1'b0;
      writeAddress_p1 <= '0;
      dataOut_p1      <= '0;
      fillBusy_p1     <= 1'b0;
      fillDone_p1     <= 1'b0;
    end else begin
      cpuVld_p0 <= bus.iCpuWrite;

      if (startAccept) begin
        pixelCount <= '0;
        cx         <= bus.iFillX0;
        cy         <= bus.iFillY0;
        col        <= '0;
        row        <= '0;
      end else if (fillStep) begin
        pixelCount <= pixelCount + COUNT_ONE;
        if (rowEnd) begin
          cx  <= x0;
          col <= '0;
          cy  <= cy + COORD_ONE;
          row <= row + COORD_ONE;
        end else begin
          cx  <= cx + COORD_ONE;
          col <= col + COORD_ONE;
        end
      end

      // Stage p1: registered VRAM write port and status
      writeEnable_p1 <= cpuVld_p0 || fillStep;
      if (cpuVld_p0) begin
        writeAddress_p1 <= cpuAddr_p0;
        dataOut_p1      <= cpuColor_p0;
      end else if (fillStep) begin
        writeAddress_p1 <= {cy, cx};
        dataOut_p1      <= fillColor;
      end else begin
        writeAddress_p1 <= '0;
        dataOut_p1      <= '0;
      end
      fillBusy_p1 <= (state != IDLE) || (nextState != IDLE);
      fillDone_p1 <= (state == DONE);
    end
  end

  assign bus.oWriteEnable  = writeEnable_p1;
  assign bus.oWriteAddress = writeAddress_p1;
  assign bus.oDataOut      = dataOut_p1;
  assign bus.oFillBusy     = fillBusy_p1;
  assign bus.oFillDone     = fillDone_p1;
  assign bus.oPixelCount   = pixelCount;
endmodule

// File: tb/tb_vga_vram_write_arbiter.sv
// Bench for the VRAM write arbiter: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based model of the fill rectangle and CPU writes.
module tb_vga_vram_write_arbiter;
  localparam int CW = 8;
  localparam int KW = 3;
  localparam int SIDE = 1 << CW;

  typedef struct packed {
    logic [15:0] addr;
    logic [2:0]  color;
  } pix_t;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  vga_vram_write_arbiter_if #(.COORD_WIDTH(CW), .COLOR_WIDTH(KW)) bus();

  vga_vram_write_arbiter #(.COORD_WIDTH(CW), .COLOR_WIDTH(KW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  pix_t        fillQ[$];
  int          mMode;
  logic [15:0] mCount;
  logic        mCpuPend;
  logic [15:0] mCpuAddr;
  logic [2:0]  mCpuColor;
  int          modelWrites;

  logic        eWe, eBusy, eDone;
  logic [15:0] eAddr;
  logic [2:0]  eData;

  logic [15:0] seenAddr[$];
  logic [2:0]  seenData[$];
  int          seenDone;

  logic [15:0] expBasic [8] = '{16'h140A, 16'h140B, 16'h140C, 16'h150A, 16'h150B, 16'h150C, 16'h0, 16'h0};
  logic [15:0] expCpu   [8] = '{16'h140A, 16'h140B, 16'h0705, 16'h140C, 16'h150A, 16'h150B, 16'h150C, 16'h0};
  logic [15:0] expWrap  [8] = '{16'hFFFE, 16'hFFFF, 16'hFF00, 16'h00FE, 16'h00FF, 16'h0000, 16'h0, 16'h0};
  logic [15:0] expIgn   [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0, 16'h0, 16'h0, 16'h0};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    fillQ.delete();
    mMode     = 0;
    mCount    = '0;
    mCpuPend  = 1'b0;
    mCpuAddr  = '0;
    mCpuColor = '0;
  endtask

  // Mode 0 idle, 1 painting the rectangle, 2 signalling completion.
  task automatic modelEdge();
    int   nextMode;
    pix_t p;
    eWe = 1'b0; eAddr = '0; eData = '0; eDone = 1'b0;
    nextMode = mMode;
    if (mCpuPend) begin
      eWe = 1'b1; eAddr = mCpuAddr; eData = mCpuColor;
    end
    case (mMode)
      0: if (bus.iFillStart) begin
           mCount = '0;
           fillQ.delete();
           if (bus.iFillW == 0 || bus.iFillH == 0) nextMode = 2;
           else begin
             for (int r = 0; r < int'(bus.iFillH); r++)
               for (int c = 0; c < int'(bus.iFillW); c++) begin
                 p.addr  = 16'(((int'(bus.iFillY0) + r) % SIDE) * SIDE + (int'(bus.iFillX0) + c) % SIDE);
                 p.color = bus.iFillColor;
                 fillQ.push_back(p);
               end
             nextMode = 1;
           end
         end
      1: if (!mCpuPend) begin
           p = fillQ.pop_front();
           eWe = 1'b1; eAddr = p.addr; eData = p.color;
           mCount = mCount + 16'd1;
           modelWrites++;
           if (fillQ.size() == 0) nextMode = 2;
         end
      default: begin
           eDone = 1'b1;
           nextMode = 0;
         end
    endcase
    eBusy     = (nextMode != 0) || eDone;
    mMode     = nextMode;
    mCpuPend  = bus.iCpuWrite;
    mCpuAddr  = {bus.iCpuY, bus.iCpuX};
    mCpuColor = bus.iCpuColor;
  endtask

  task automatic cycle();
    @(posedge Clock);
    modelEdge();
    @(negedge Clock);
    check("we",    32'(bus.oWriteEnable),  32'(eWe));
    check("addr",  32'(bus.oWriteAddress), 32'(eAddr));
    check("data",  32'(bus.oDataOut),      32'(eData));
    check("busy",  32'(bus.oFillBusy),     32'(eBusy));
    check("done",  32'(bus.oFillDone),     32'(eDone));
    check("count", 32'(bus.oPixelCount),   32'(mCount));
    if (bus.oWriteEnable === 1'b1) begin
      seenAddr.push_back(bus.oWriteAddress);
      seenData.push_back(bus.oDataOut);
    end
    if (bus.oFillDone === 1'b1) seenDone++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic startFill(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                           input logic [7:0] h, input logic [2:0] c);
    bus.iFillX0 = x; bus.iFillY0 = y; bus.iFillW = w; bus.iFillH = h; bus.iFillColor = c;
    bus.iFillStart = 1'b1;
    cycle();
    bus.iFillStart = 1'b0;
  endtask

  task automatic clearSeen();
    seenAddr.delete();
    seenData.delete();
    seenDone = 0;
  endtask

  task automatic checkSeq(input string tag, input logic [15:0] exp[8], input int n);
    check({tag, "_len"}, 32'(seenAddr.size()), 32'(n));
    for (int i = 0; i < n; i++)
      check($sformatf("%s_addr%0d", tag, i),
            (i < seenAddr.size()) ? 32'(seenAddr[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  task automatic checkZeroOutputs(input string tag);
    check({tag, "_we"},    32'(bus.oWriteEnable),  32'd0);
    check({tag, "_addr"},  32'(bus.oWriteAddress), 32'd0);
    check({tag, "_data"},  32'(bus.oDataOut),      32'd0);
    check({tag, "_busy"},  32'(bus.oFillBusy),     32'd0);
    check({tag, "_done"},  32'(bus.oFillDone),     32'd0);
    check({tag, "_count"}, 32'(bus.oPixelCount),   32'd0);
  endtask

  initial begin
    bus.iCpuWrite = 1'b0; bus.iCpuX = '0; bus.iCpuY = '0; bus.iCpuColor = '0;
    bus.iFillStart = 1'b0; bus.iFillX0 = '0; bus.iFillY0 = '0;
    bus.iFillW = '0; bus.iFillH = '0; bus.iFillColor = '0;
    modelReset();
    modelWrites = 0;
    clearSeen();

    #1 checkZeroOutputs("reset");
    @(negedge Clock);
    Reset = 1'b1;
    run(2);

    clearSeen();
    startFill(8'd10, 8'd20, 8'd3, 8'd2, 3'b100);
    run(10);
    checkSeq("basic", expBasic, 6);
    check("basic_done", 32'(seenDone), 32'd1);
    check("basic_count", 32'(bus.oPixelCount), 32'd6);
    foreach (seenData[i]) check($sformatf("basic_data%0d", i), 32'(seenData[i]), 32'd4);

    clearSeen();
    startFill(8'd10, 8'd20, 8'd3, 8'd2, 3'b100);
    cycle();
    bus.iCpuX = 8'd5; bus.iCpuY = 8'd7; bus.iCpuColor = 3'b010; bus.iCpuWrite = 1'b1;
    cycle();
    bus.iCpuWrite = 1'b0;
    run(10);
    checkSeq("cpu", expCpu, 7);
    check("cpu_data", (seenData.size() > 2) ? 32'(seenData[2]) : 32'hFFFF_FFFF, 32'd2);
    check("cpu_done", 32'(seenDone), 32'd1);

    clearSeen();
    startFill(8'd254, 8'd255, 8'd3, 8'd2, 3'b001);
    run(10);
    checkSeq("wrap", expWrap, 6);

    clearSeen();
    startFill(8'd3, 8'd3, 8'd0, 8'd5, 3'b010);
    run(4);
    check("zero_writes", 32'(seenAddr.size()), 32'd0);
    check("zero_done", 32'(seenDone), 32'd1);

    clearSeen();
    startFill(8'd0, 8'd0, 8'd4, 8'd1, 3'b001);
    bus.iFillX0 = 8'd50; bus.iFillY0 = 8'd50; bus.iFillW = 8'd2; bus.iFillH = 8'd2;
    bus.iFillColor = 3'b111; bus.iFillStart = 1'b1;
    cycle();
    bus.iFillStart = 1'b0;
    run(8);
    checkSeq("ignored", expIgn, 4);

    clearSeen();
    modelWrites = 0;
    startFill(8'd0, 8'd0, 8'd100, 8'd100, 3'b101);
    for (int i = 0; i < 200 && modelWrites < 50; i++) cycle();
    check("rst_reach50", 32'(modelWrites), 32'd50);
    #2 Reset = 1'b0;
    #1 checkZeroOutputs("rst_async");
    modelReset();
    @(negedge Clock);
    checkZeroOutputs("rst_hold");
    Reset = 1'b1;
    clearSeen();
    run(5);
    check("rst_nowrite", 32'(seenAddr.size()), 32'd0);
    startFill(8'd9, 8'd9, 8'd1, 8'd1, 3'b110);
    run(5);
    check("one_writes", 32'(seenAddr.size()), 32'd1);
    check("one_addr", (seenAddr.size() > 0) ? 32'(seenAddr[0]) : 32'hFFFF_FFFF, 32'h0909);

    for (int i = 0; i < 2000; i++) begin
      bus.iCpuWrite  = ($urandom_range(0, 3) == 0);
      bus.iCpuX      = 8'($urandom);
      bus.iCpuY      = 8'($urandom);
      bus.iCpuColor  = 3'($urandom);
      bus.iFillStart = ($urandom_range(0, 7) == 0);
      bus.iFillX0    = 8'($urandom);
      bus.iFillY0    = 8'($urandom);
      bus.iFillW     = 8'($urandom_range(0, 5));
      bus.iFillH     = 8'($urandom_range(0, 5));
      bus.iFillColor = 3'($urandom);
      cycle();
    end
    bus.iCpuWrite = 1'b0;
    bus.iFillStart = 1'b0;
    run(60);
    check("final_idle", 32'(bus.oFillBusy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
